// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// the baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer division; the caller guarantees a result of at least 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the head entry, so a pop
// and the use of the popped data happen in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally; the level counter alone tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and level decide which
  // entries are valid, and leaving it unreset lets it map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds a start/data/stop
// serialiser that sends queued frames back to back with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic [7:0]                  I_data,
  input  logic                        I_valid,
  output logic                        O_ready,
  output logic                        O_tx,
  output logic                        O_busy,
  output logic [$clog2(FIFO_DEPTH):0] O_level
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int         CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

  uart_tx_state_t   state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done;

  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign bit_done  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign O_ready   = !fifo_full;
  assign fifo_push = I_valid && O_ready;
  // Pop only where the FSM is about to start a new frame.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (I_clk),
    .rst   (I_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (I_data),
    .dout  (fifo_dout),
    .level (O_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values of state, counters and shift register.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      O_tx     <= 1'b1;
      O_busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          O_tx     <= 1'b1;
          O_busy   <= 1'b0;
          if (fifo_pop) begin
            shift  <= fifo_dout;
            O_tx   <= 1'b0;
            O_busy <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            O_tx     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              O_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              O_tx    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more data waits.
            if (fifo_pop) begin
              shift <= fifo_dout;
              O_tx  <= 1'b0;
              state <= START;
            end else begin
              O_busy <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter driving the board `uart_tx` pin.
- Return path for the UART command receiver: control logic, status and readback sources push bytes, and the block serialises them to the host.
- Sits in the 27 MHz `I_clk` domain beside the receiver and uses the same baud parameters.

Parameters:
- CLK_FREQ, 27000000, input clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (234 at defaults). Must be ≥ 2.
- FIFO_DEPTH, 16, byte FIFO entries. Must be a power of two, ≥ 2.

Ports:
- I_clk  in  1  system clock.
- I_rst  in  1  synchronous reset, active-high.
- I_data  in  8  byte to transmit.
- I_valid  in  1  I_data is valid this cycle.
- O_ready  out  1  FIFO can accept a byte this cycle.
- O_tx  out  1  serial line, idle high.
- O_busy  out  1  a frame is on the line.
- O_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy (0..FIFO_DEPTH).

Behaviour:
- One clock (I_clk); reset is synchronous and active-high (I_rst). Everything updates on posedge I_clk.
- Reset values:
  - O_tx=1, O_busy=0, O_level=0, O_ready=1.
  - FIFO pointers cleared, FSM=IDLE, baud counter=0, bit index=0.
- Push handshake:
  - A byte is accepted when I_valid && O_ready at a rising edge.
  - O_ready = (O_level != FIFO_DEPTH), combinational from registered level.
  - I_valid while O_ready=0 is ignored; no overwrite and no error flag.
  - I_data only needs to be stable in the accepting cycle.
- Pop: done internally by the FSM only, in the cycle it leaves IDLE or STOP toward START.
- Simultaneous push and pop:
  - Both take effect and O_level is unchanged.
  - When full, O_ready=0, so the push is refused even if a pop occurs in the same cycle.
- FSM states are IDLE, START, DATA, STOP. "Bit done" means baud counter = CLKS_PER_BIT-1; the counter is reset to 0 on every bit transition.
  - IDLE:
    - O_tx=1, O_busy=0.
    - If FIFO is non-empty: pop the head into the shift register, drive O_tx<=0, set O_busy<=1, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - Drive shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, then shift right.
    - After bit index 7, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. On completion:
    - If FIFO is non-empty: pop and go directly to START. No idle gap, and O_busy stays 1.
    - Otherwise: go to IDLE and O_busy<=0.
- Latency and frame timing:
  - Byte accepted at edge N into an empty FIFO with FSM idle → O_tx falls at edge N+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles of O_busy=1.
- Reset mid-frame: at that edge O_tx=1, O_busy=0, FIFO is emptied, and the partial frame is abandoned. No trailing bits are sent.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. The level counter separates full from empty.
- FIFO storage may be inferred distributed RAM or registers. The read data must be valid in the same cycle the pop is asserted, so use a combinational read of the head entry.

Decomposition:
- Shared package `uart_pkg`:
  - enum `uart_tx_state_t` {IDLE, START, DATA, STOP}.
  - constant function `clks_per_bit(clk_freq, baud)`, reused by the receiver.
  - localparams DATA_BITS=8, STOP_BITS=1.
- One sub-module `sync_fifo`:
  - Parameters WIDTH, DEPTH; ports push/pop/din/dout/level/full/empty.
  - Show-ahead read.
- The top of this block holds the FSM, baud counter and shift register.

Test Plan (CLK_FREQ=16, BAUD=1 → CLKS_PER_BIT=16):
1. Hold I_rst=1 for 3 cycles, then release → O_tx=1, O_busy=0, O_ready=1, O_level=0. The line stays high for 100 idle cycles.
2. Push 0x55 at edge N:
   - O_tx falls at N+1.
   - Line samples at bit centres read 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop).
   - O_busy is high for exactly 160 cycles.
3. Push 0xA5 then 0x3C on consecutive cycles:
   - Two frames back to back: data bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
   - No idle cycle between the stop bit and the second start bit.
   - O_busy is high for 320 contiguous cycles.
4. Hold I_valid=1 with an incrementing byte for 30 cycles from idle:
   - Exactly 17 bytes are accepted: the first is popped immediately, then the FIFO fills to 16.
   - O_ready=0 when O_level=16; refused bytes never appear on the line.
   - All 17 frames are transmitted in order.
5. Full FIFO, I_valid=1 held at the STOP→START pop edge → the push is refused and O_level goes 16→15.
6. Assert I_rst for 1 cycle in the middle of DATA bit 3 of a frame, with 5 bytes queued:
   - At that edge O_tx=1, O_busy=0, O_level=0.
   - No further frames are sent.
   - A subsequent push of 0x0F transmits correctly.
